// File: rtl/crosswalk_request.sv
`default_nettype none
// ============================================================================
// Module   : crosswalk_request
// Brief    : Pedestrian push-button synchronizer, debouncer and request latch
//            with post-service hold-off and saturating press counter.
// Revision : 1.0 - initial release
// ============================================================================

module crosswalk_request #(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int HOLDOFF_TICKS  = 8,
    parameter int COUNT_W        = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               button_n,
    input  logic               ack,
    output logic               req,
    output logic               pressed,
    output logic               holdoff,
    output logic [COUNT_W-1:0] press_count
);

    localparam int c_DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int c_HO_W = (HOLDOFF_TICKS > 0) ? $clog2(HOLDOFF_TICKS + 1) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE_TICKS);
    localparam logic [c_HO_W-1:0]  c_HO_LOAD = c_HO_W'(HOLDOFF_TICKS);
    localparam logic [COUNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DB_W-1:0]   r_cnt;
    logic [c_DB_W-1:0]   w_cnt_nxt;
    logic                w_press_evt;
    logic                w_pressed_nxt;

    logic                r_sync1;
    logic                r_sync2;
    logic                w_btn_s;

    logic                r_req;
    logic                r_pressed;
    logic                r_holdoff;
    logic [c_HO_W-1:0]   r_ho_cnt;
    logic [c_HO_W-1:0]   w_ho_nxt;
    logic                w_req_nxt;
    logic [COUNT_W-1:0]  r_press_count;

    // Flops reset to the released level so a held button looks like a new press.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= button_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = ~r_sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_evt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_btn_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = c_DB_W'(1);
                end
            end
            S_PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DB_MAX) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                    w_press_evt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_DB_W'(1);
                end
            end
            S_PRESSED: begin
                w_cnt_nxt = '0;
                if (!w_btn_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = c_DB_W'(1);
                end
            end
            S_RELEASE_WAIT: begin
                if (w_btn_s) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_DB_MAX) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_DB_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The debounced level stays high through the release-qualification window.
    assign w_pressed_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_WAIT);

    always_comb begin
        w_ho_nxt  = (r_ho_cnt != '0) ? (r_ho_cnt - c_HO_W'(1)) : '0;
        w_req_nxt = r_req;
        if (ack && r_req) begin
            // Service wins over a coincident press; that press is only counted.
            w_req_nxt = 1'b0;
            if (HOLDOFF_TICKS > 0) begin
                w_ho_nxt = c_HO_LOAD;
            end
        end else if (w_press_evt && !r_holdoff) begin
            w_req_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pressed     <= 1'b0;
            r_req         <= 1'b0;
            r_ho_cnt      <= '0;
            r_holdoff     <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_pressed <= w_pressed_nxt;
            r_req     <= w_req_nxt;
            r_ho_cnt  <= w_ho_nxt;
            r_holdoff <= (w_ho_nxt != '0);
            if (w_press_evt && (r_press_count != c_CNT_MAX)) begin
                r_press_count <= r_press_count + COUNT_W'(1);
            end
        end
    end

    assign req         = r_req;
    assign pressed     = r_pressed;
    assign holdoff     = r_holdoff;
    assign press_count = r_press_count;

endmodule

`default_nettype wire

// File: doc/crosswalk_request.md
Name: crosswalk_request

Overview:
- Upstream input stage for the traffic-light controller. Synchronizes and debounces the raw active-low pedestrian push-button, then latches a pedestrian request.
- The controller reads `req` and returns a one-cycle `ack` when it serves the request.
- A hold-off window after each service ignores repeat presses.
- Runs on the same slow system clock as the timer and light FSM.

Parameters:
- DEBOUNCE_TICKS, 2, consecutive stable synchronized samples required to accept a press or release. Legal range ≥1.
- HOLDOFF_TICKS, 8, cycles after an accepted `ack` during which presses do not set `req`. 0 disables hold-off.
- COUNT_W, 8, width of the saturating press counter.

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- button_n  input  1  raw asynchronous push-button, active low
- ack  input  1  one-cycle pulse from controller: request served
- req  output  1  latched pedestrian request, level
- pressed  output  1  debounced button level (1 = held)
- holdoff  output  1  hold-off window active
- press_count  output  COUNT_W  saturating count of debounced presses

Behaviour:
- Reset (synchronous, highest priority, legal at any time):
  - Sync flops load 1 (released); FSM enters IDLE; debounce counter 0.
  - req=0, pressed=0, holdoff=0, press_count=0, hold-off counter 0.
  - A button still held when reset is released is treated as a fresh press.
- Synchronizer: two flops on `button_n`. btn_s = NOT second flop.
- Debounce FSM, counter cnt sized to hold DEBOUNCE_TICKS:
  - IDLE: pressed=0. If btn_s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - btn_s=0 → IDLE, cnt=0.
    - btn_s=1 and cnt==DEBOUNCE_TICKS → PRESSED, and raise the internal one-cycle press_evt.
    - Otherwise cnt+1.
  - PRESSED: pressed=1. If btn_s=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - btn_s=1 → PRESSED, cnt=0.
    - btn_s=0 and cnt==DEBOUNCE_TICKS → IDLE.
    - Otherwise cnt+1.
- Latency:
  - Number edges from the first rising edge that samples button_n=0.
  - With button_n held low, pressed, req and the press_count increment become visible after edge DEBOUNCE_TICKS+3 (edge 5 at default).
  - Release is symmetric: pressed drops after edge DEBOUNCE_TICKS+3 of a continuous high.
- press_count:
  - Increments on every press_evt, independent of hold-off or req.
  - Saturates at 2^COUNT_W−1; no wrap.
- req latch, evaluated in priority order each edge:
  1. ack=1 and req=1: req←0. If HOLDOFF_TICKS>0, load hold-off counter with HOLDOFF_TICKS and set holdoff=1. A press_evt on the same edge is discarded (req stays 0) but still counted.
  2. ack=1 and req=0: ignored. No hold-off starts and req is unchanged, except that a coincident press_evt with holdoff=0 sets req←1.
  3. press_evt=1 and holdoff=0: req←1. If req is already 1, it stays 1; presses do not queue.
  4. press_evt=1 and holdoff=1: press ignored for req.
- Hold-off counter:
  - Decrements each cycle while nonzero.
  - holdoff = (counter≠0); holdoff stays high for exactly HOLDOFF_TICKS cycles after the ack edge.
  - A press_evt on the edge where the counter reaches 0 is still ignored. Presses are accepted from the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (DEBOUNCE_TICKS=2, HOLDOFF_TICKS=8, COUNT_W=8):
1. Clean press: button_n low 12 cycles, then high 12 cycles → pressed=1, req=1 and press_count=1 after edge 5 of the low interval; pressed=0 after edge 5 of the high interval; req remains 1.
2. Bounce rejection: button_n low 2, high 1, low 1, high 10 (cycles) → pressed, req and press_count stay 0 throughout.
3. Service and hold-off: with req=1, pulse ack for 1 cycle → req=0 next edge; holdoff=1 for exactly 8 cycles. A press completing inside the window → press_count increments, req stays 0. A press completing after holdoff falls → req=1.
4. Simultaneous events:
   - press_evt on the same edge as ack with req=1 → req=0, holdoff=1, press_count increments.
   - ack while req=0 → holdoff stays 0.
5. Saturation: 260 clean press/release pairs → press_count reaches 255 and holds; req behaviour is unaffected.
6. Reset mid-operation: assert reset for 1 cycle during PRESS_WAIT with req=1 and holdoff=1 → all outputs 0 next edge. Button still held → pressed and req reassert 5 edges after reset deasserts.
